// File: rtl/reg_display_scanner.sv
// reg_display_scanner: shows a 32-bit datapath debug value on an 8-digit 7-segment display and steps the register index with debounced buttons
module reg_display_scanner #(
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        BtnNext,
  input  logic        BtnPrev,
  input  logic        Hold,
  input  logic        Mode,
  output logic [4:0]  DispReadReg,
  input  logic [31:0] DispRegData,
  input  logic [31:0] PCNext,
  output logic [7:0]  An,
  output logic [7:0]  Seg,
  output logic [4:0]  Led
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(REFRESH_DIV + 1);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SMAX = SW'(REFRESH_DIV);

  logic [1:0]         s1_q, s2_q, deb_q, deb_d, rise;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [4:0]         idx_q, idx_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [2:0]         digit_q, digit_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [31:0]        shown_q, shown_d;
  logic [7:0]         an_q, an_d, seg_q, seg_d;
  logic [6:0]         hex;
  logic [3:0]         nib;
  logic               tc, frame;

  // debounce both buttons (bit 0 = next, bit 1 = prev); a rise pulse fires on the cycle the debounced level goes high
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (s2_q[i] == deb_q[i] || cnt_q[i] == CMAX) ? '0 : cnt_q[i] + 1'b1;
      deb_d[i] = (s2_q[i] != deb_q[i] && cnt_q[i] == CMAX) ? s2_q[i] : deb_q[i];
      rise[i]  = deb_d[i] & ~deb_q[i];
    end
    idx_d    = rise == 2'b01 ? idx_q + 5'd1 : rise == 2'b10 ? idx_q - 5'd1 : idx_q;
    settle_d = idx_d != idx_q ? SMAX : settle_q != '0 ? settle_q - 1'b1 : settle_q;
  end

  // digit scan, frame sampling (regfile data only once it has settled after an index change) and display word
  always_comb begin
    tc      = presc_q == PMAX;
    frame   = tc && digit_q == 3'd7;
    presc_d = tc ? '0 : presc_q + 1'b1;
    digit_d = tc ? digit_q + 3'd1 : digit_q;
    shown_d = (frame && !Hold && (Mode || settle_q == '0)) ? (Mode ? PCNext : DispRegData) : shown_q;
    nib     = 4'(shown_q >> {digit_q, 2'b00});
    an_d    = ~(8'b1 << digit_q);
    seg_d   = {~(Mode && digit_q == 3'd7), hex};
  end

  // active-low gfedcba hex glyphs
  always_comb begin
    case (nib)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      default: hex = 7'b0001110;
    endcase
  end

  // all state, cleared asynchronously by Reset low
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      presc_q  <= '0;
      digit_q  <= '0;
      shown_q  <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      s1_q     <= {BtnPrev, BtnNext};
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      shown_q  <= shown_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign DispReadReg = idx_q;
  assign Led         = idx_q;
  assign An          = an_q;
  assign Seg         = seg_q;
endmodule

// File: tb/tb_reg_display_scanner.sv
// tb_reg_display_scanner: scoreboard bench for the debug display scanner
module tb_reg_display_scanner;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        BtnNext = 1'b0;
  logic        BtnPrev = 1'b0;
  logic        Hold = 1'b0;
  logic        Mode = 1'b0;
  logic [31:0] DispRegData = '0;
  logic [31:0] PCNext = '0;
  logic [4:0]  DispReadReg, Led;
  logic [7:0]  An, Seg;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [2:0] d;
    logic [7:0] seg;
  } exp_t;
  exp_t q[$];

  localparam logic [7:0] V1234 [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  localparam logic [7:0] VPC   [8] = '{8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hC0, 8'h40};

  reg_display_scanner #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .CLK(CLK), .Reset(Reset), .BtnNext(BtnNext), .BtnPrev(BtnPrev), .Hold(Hold), .Mode(Mode),
    .DispReadReg(DispReadReg), .DispRegData(DispRegData), .PCNext(PCNext),
    .An(An), .Seg(Seg), .Led(Led)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge CLK) begin : monitor
    exp_t e;
    logic [7:0] want_an;
    if (Reset && q.size() > 0) begin
      want_an = ~(8'b1 << q[0].d);
      if (An == want_an) begin
        e = q.pop_front();
        compared++;
        if (Seg !== e.seg) begin
          mismatched++;
          $display("FAIL seg_digit%0d: Seg=%h expected %h", e.d, Seg, e.seg);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [7:0] v);
    int n = 0;
    @(negedge CLK);
    while (An === v && n < 200) begin @(negedge CLK); n++; end
    while (An !== v && n < 200) begin @(negedge CLK); n++; end
    if (An !== v) begin
      compared++;
      mismatched++;
      $display("FAIL wait_an: An=%h never reached %h", An, v);
    end
  endtask

  task automatic push_frame(input int s);
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      e.d = 3'(d);
      e.seg = s == 0 ? V1234[d] : s == 1 ? 8'hC0 : VPC[d];
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin @(negedge CLK); n++; end
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expected digits never shown", q.size());
      q.delete();
    end
  endtask

  task automatic press(input logic n, input logic p, input int cyc);
    @(negedge CLK);
    BtnNext = n;
    BtnPrev = p;
    repeat (cyc) @(negedge CLK);
    BtnNext = 1'b0;
    BtnPrev = 1'b0;
    repeat (12) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] exp_an;
    int n;
    repeat (3) @(negedge CLK);
    check("rst_an", An, 8'hFF);
    check("rst_seg", Seg, 8'hFF);
    check("rst_idx", DispReadReg, 0);
    check("rst_led", Led, 0);
    Reset = 1'b1;
    press(1, 0, 8);
    check("next_long", DispReadReg, 1);
    press(1, 0, 2);
    check("next_short", DispReadReg, 1);
    press(0, 1, 8);
    check("prev_to0", DispReadReg, 0);
    press(0, 1, 8);
    check("prev_wrap", DispReadReg, 31);
    check("led_mirror", Led, 31);
    press(1, 0, 8);
    check("next_wrap", DispReadReg, 0);
    press(1, 1, 8);
    check("both_same", DispReadReg, 0);
    press(1, 0, 8);
    press(1, 0, 8);
    check("idx_two", DispReadReg, 2);
    repeat (5) @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("mid_rst_an", An, 8'hFF);
    check("mid_rst_seg", Seg, 8'hFF);
    check("mid_rst_idx", DispReadReg, 0);
    check("mid_rst_led", Led, 0);
    @(negedge CLK);
    Reset = 1'b1;
    n = 0;
    while (An !== 8'hFE && n < 2) begin @(negedge CLK); n++; end
    check("an_first", An, 8'hFE);
    for (int k = 1; k <= 8; k++) begin
      repeat (4) @(negedge CLK);
      exp_an = ~(8'b1 << (k % 8));
      check("an_step", An, exp_an);
    end
    wait_an(8'hFE);
    DispRegData = 32'h1234ABCD;
    wait_an(8'h7F);
    push_frame(0);
    drain();
    wait_an(8'hFE);
    Hold = 1'b1;
    DispRegData = 32'h0;
    wait_an(8'h7F);
    push_frame(0);
    push_frame(0);
    push_frame(0);
    drain();
    wait_an(8'hFE);
    Hold = 1'b0;
    wait_an(8'h7F);
    push_frame(1);
    drain();
    wait_an(8'hFE);
    Mode = 1'b1;
    PCNext = 32'h00400008;
    wait_an(8'h7F);
    push_frame(2);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
